// File: rtl/onehot_grant_decoder_if.sv
// Request/grant bundle between the encoder, onehot_grant_decoder and the grantees.
// master drives requests and done; slave is the decoder.
interface onehot_grant_decoder_if #(
  parameter int IDX_W = 2
);
  localparam int GNT_W = 2**IDX_W;

  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_error;
  logic             req_ready;
  logic [GNT_W-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             done;
  logic             timeout;
  logic [7:0]       err_cnt;

  modport master (
    output req_valid, req_idx, req_error, done,
    input  req_ready, grant, grant_valid, grant_idx, timeout, err_cnt
  );

  modport slave (
    input  req_valid, req_idx, req_error, done,
    output req_ready, grant, grant_valid, grant_idx, timeout, err_cnt
  );
endinterface

// File: rtl/onehot_grant_decoder.sv
// Turns an encoded index into a registered one-hot grant, held until done or
// a hold timeout, with a one-entry pending slot for back-to-back grants.
module onehot_grant_decoder #(
  parameter int IDX_W    = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  onehot_grant_decoder_if.slave bus
);
  localparam int         GNT_W     = 2**IDX_W;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_n;
  logic [GNT_W-1:0] grant_q, grant_n;
  logic [IDX_W-1:0] gidx_q, gidx_n;
  logic [IDX_W-1:0] pidx_q, pidx_n;
  logic             pvld_q, pvld_n;
  logic [7:0]       hold_q, hold_n;
  logic [7:0]       errc_q, errc_n;
  logic             to_q, to_n;
  logic             acc_ok, acc_err, term;

  // Ready depends only on the pending register, so no path from req_valid.
  assign bus.req_ready   = !pvld_q;
  assign acc_ok          = bus.req_valid && !pvld_q && !bus.req_error;
  assign acc_err         = bus.req_valid && !pvld_q &&  bus.req_error;
  assign term            = bus.done || (hold_q == HOLD_LAST);

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = gidx_q;
  assign bus.timeout     = to_q;
  assign bus.err_cnt     = errc_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      pidx_q  <= '0;
      pvld_q  <= 1'b0;
      hold_q  <= '0;
      errc_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      gidx_q  <= gidx_n;
      pidx_q  <= pidx_n;
      pvld_q  <= pvld_n;
      hold_q  <= hold_n;
      errc_q  <= errc_n;
      to_q    <= to_n;
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    gidx_n  = gidx_q;
    pidx_n  = pidx_q;
    pvld_n  = pvld_q;
    hold_n  = hold_q;
    to_n    = 1'b0;
    errc_n  = errc_q;

    if (acc_err && errc_q != 8'hFF) errc_n = errc_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (acc_ok) begin
          state_n = GRANT;
          grant_n = GNT_W'(1) << bus.req_idx;
          gidx_n  = bus.req_idx;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (term) begin
          // done beats an expiring hold counter in the same cycle
          to_n   = !bus.done;
          hold_n = '0;
          if (pvld_q) begin
            grant_n = GNT_W'(1) << pidx_q;
            gidx_n  = pidx_q;
            pvld_n  = 1'b0;
          end else if (acc_ok) begin
            grant_n = GNT_W'(1) << bus.req_idx;
            gidx_n  = bus.req_idx;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else begin
          hold_n = hold_q + 8'd1;
          if (acc_ok) begin
            pvld_n = 1'b1;
            pidx_n = bus.req_idx;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed, table-driven bench for onehot_grant_decoder (IDX_W=2, HOLD_MAX=8).
module tb_onehot_grant_decoder;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  onehot_grant_decoder_if #(.IDX_W(2)) bus ();
  onehot_grant_decoder #(.IDX_W(2), .HOLD_MAX(8)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic       err;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gidx;
    logic       rdy;
    logic       to;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic v, input logic [1:0] idx, input logic err, input logic done,
                     input logic [3:0] gnt, input logic [1:0] gidx, input logic rdy,
                     input logic to, input logic [7:0] ec);
    vec_t r;
    r.v = v; r.idx = idx; r.err = err; r.done = done;
    r.gnt = gnt; r.gidx = gidx; r.rdy = rdy; r.to = to; r.ec = ec;
    vecs.push_back(r);
  endtask

  task automatic add_idle(input int n, input logic [3:0] gnt, input logic [1:0] gidx,
                          input logic rdy, input logic [7:0] ec);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, gnt, gidx, rdy, 0, ec);
  endtask

  task automatic check_outs(input string nm, input logic [3:0] gnt, input logic [1:0] gidx,
                            input logic rdy, input logic to, input logic [7:0] ec);
    logic [15:0] act, exp;
    act = {bus.grant, bus.grant_valid, bus.grant_idx, bus.req_ready, bus.timeout, bus.err_cnt};
    exp = {gnt, |gnt, gidx, rdy, to, ec};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got grant=%b gv=%b gidx=%0d rdy=%b to=%b ec=%0d, want grant=%b gv=%b gidx=%0d rdy=%b to=%b ec=%0d",
               nm, bus.grant, bus.grant_valid, bus.grant_idx, bus.req_ready, bus.timeout, bus.err_cnt,
               gnt, |gnt, gidx, rdy, to, ec);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic err, input logic done);
    @(negedge clk);
    bus.req_valid = v; bus.req_idx = idx; bus.req_error = err; bus.done = done;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t r, input string nm);
    drive(r.v, r.idx, r.err, r.done);
    check_outs(nm, r.gnt, r.gidx, r.rdy, r.to, r.ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_idx = 0; bus.req_error = 0; bus.done = 0;

    // args: v idx err done | grant gidx rdy to err_cnt
    add(1, 2, 0, 0, 4'b0100, 2, 1, 0, 0);     // basic grant of idx 2
    add(0, 0, 0, 0, 4'b0100, 2, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0000, 2, 1, 0, 0);     // done releases, gidx holds
    add(1, 1, 0, 0, 4'b0010, 1, 1, 0, 0);     // back-to-back via pending
    add(1, 3, 0, 0, 4'b0010, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0010, 1, 0, 0, 0);
    add(0, 0, 0, 1, 4'b1000, 3, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0000, 3, 1, 0, 0);
    add(0, 0, 0, 1, 4'b0000, 3, 1, 0, 0);     // done ignored in IDLE
    add(1, 1, 1, 0, 4'b0000, 3, 1, 0, 1);     // error requests never grant
    add(1, 1, 1, 0, 4'b0000, 3, 1, 0, 2);
    add(1, 1, 1, 0, 4'b0000, 3, 1, 0, 3);
    add(1, 0, 0, 0, 4'b0001, 0, 1, 0, 3);
    add(1, 2, 1, 0, 4'b0001, 0, 1, 0, 4);     // error in GRANT: no pending
    add(0, 0, 0, 1, 4'b0000, 0, 1, 0, 4);
    add(1, 1, 0, 0, 4'b0010, 1, 1, 0, 4);
    add(1, 2, 0, 1, 4'b0100, 2, 1, 0, 4);     // direct load at termination
    add(0, 0, 0, 1, 4'b0000, 2, 1, 0, 4);
    add(1, 0, 0, 0, 4'b0001, 0, 1, 0, 4);     // timeout: 8 grant cycles
    add_idle(7, 4'b0001, 0, 1, 4);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 0, 4);
    add(1, 3, 0, 0, 4'b1000, 3, 1, 0, 4);     // done in 8th cycle wins
    add_idle(7, 4'b1000, 3, 1, 4);
    add(0, 0, 0, 1, 4'b0000, 3, 1, 0, 4);
    add(0, 0, 0, 0, 4'b0000, 3, 1, 0, 4);
    add(1, 1, 0, 0, 4'b0010, 1, 1, 0, 4);     // timeout hands off to pending
    add(1, 2, 0, 0, 4'b0010, 1, 0, 0, 4);
    add_idle(6, 4'b0010, 1, 0, 4);
    add(0, 0, 0, 0, 4'b0100, 2, 1, 1, 4);
    add(0, 0, 0, 1, 4'b0000, 2, 1, 0, 4);

    #12;
    check_outs("reset_state", 4'b0000, 0, 1, 0, 0);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // err_cnt saturation: 4 + 250 = 254, then 10 more clamp at 255
    for (int i = 0; i < 250; i++) drive(1, 0, 1, 0);
    check_outs("err_cnt_254", 4'b0000, 2, 1, 0, 8'd254);
    for (int i = 0; i < 10; i++) drive(1, 0, 1, 0);
    check_outs("err_cnt_sat", 4'b0000, 2, 1, 0, 8'd255);

    // async reset with an active grant and a full pending slot
    drive(1, 1, 0, 0);
    drive(1, 3, 0, 0);
    check_outs("pend_full", 4'b0010, 1, 0, 0, 8'd255);
    @(negedge clk);
    bus.req_valid = 0; bus.done = 0;
    #2 rstN = 1'b0;
    #1 check_outs("async_reset", 4'b0000, 0, 1, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    drive(1, 2, 0, 0);
    check_outs("post_rst_grant", 4'b0100, 2, 1, 0, 0);
    drive(0, 0, 0, 1);
    check_outs("post_rst_done", 4'b0000, 2, 1, 0, 0);
    drive(0, 0, 0, 0);
    check_outs("post_rst_idle", 4'b0000, 2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
